level_timer: RTL and testbench
==============================

// Module: level_timer
// PURPOSE
// - Per-level countdown timer; consumes the game controller's start_level / timer_time outputs.
// - Returns level_ended to the game controller.
// - Ends the level on timeout, on all_collected, or silently on abort.
// - Drives seconds-left (binary + two BCD digits) for the HUD, plus a low-time warning.
// PARAMETERS
// - TICK_DIV   31_500_000  clocks per game second; benches use 4
// - MAX_TIME   8'd99       load saturation; two HUD digits
// - LOW_TIME   8'd10       warn threshold in seconds
// PORTS
// - clk            in   1  system clock
// - resetN         in   1  asynchronous, active-low reset
// - start_level    in   1  1-cycle pulse; load timer_time and run
// - timer_time     in   8  seconds for the level; stable while start_level=1
// - pause          in   1  level: hold the countdown
// - all_collected  in   1  pulse/level: every object collected, end level early
// - abort          in   1  pulse: level skipped (wired to skip_level); stop, no level_ended
// - level_ended    out  1  1-cycle pulse, at most once per start_level
// - time_left      out  8  seconds remaining, binary
// - time_tens      out  4  BCD tens of time_left
// - time_ones      out  4  BCD ones of time_left
// - sec_tick       out  1  1-cycle pulse on every decrement
// - running        out  1  1 in RUN or PAUSED
// - low_time_warn  out  1  running && time_left!=0 && time_left<=LOW_TIME
// BEHAVIOUR
// - Reset: state IDLE, prescaler 0, all outputs 0.
// - All outputs registered.
// - States: IDLE, RUN, PAUSED, EXPIRED.
// - start_level, any state (top priority):
//   - time_left <= min(timer_time, MAX_TIME); digits loaded to match.
//   - prescaler <= 0; state <= RUN; level_ended <= 0.
// - Priority below start_level: abort > all_collected > pause > tick.
// - RUN:
//   - abort -> IDLE; time_left keeps its value; no level_ended.
//   - all_collected -> EXPIRED; level_ended=1 next cycle; time_left frozen (no decrement that cycle).
//   - time_left==0 -> EXPIRED; level_ended=1 next cycle (covers a timer_time=0 load).
//   - pause -> PAUSED; prescaler held.
//   - Otherwise prescaler++.
//   - At prescaler==TICK_DIV-1: prescaler<=0; time_left--; digits decrement BCD-wise (x0 -> (x-1)9); sec_tick=1.
//   - When time_left reaches 0, the next cycle expires as above.
//   - Expiry latency from the final tick: 2 clocks.
// - PAUSED:
//   - abort -> IDLE.
//   - all_collected -> EXPIRED + level_ended.
//   - !pause -> RUN; prescaler resumes from its held value.
//   - Pause therefore delays expiry by exactly the number of paused cycles.
// - EXPIRED:
//   - level_ended is high for exactly the entry cycle, then 0.
//   - Hold time_left; ignore pause, all_collected and abort until start_level.
// - IDLE: ignore everything except start_level.
// - Arithmetic:
//   - time_left never wraps below 0.
//   - Prescaler width $clog2(TICK_DIV); it never exceeds TICK_DIV-1.
// STRUCTURE
// - game_pkg: typedef enum timer_state_t {IDLE,RUN,PAUSED,EXPIRED}; localparams TIME_W=8, BCD_W=4.
// - Sub-module bin2bcd_99: combinational 0..99 -> {tens,ones}; used only at load.
// - Runtime digits are maintained by BCD decrement, not re-converted.
// TESTING (TICK_DIV=4)
// - start_level with timer_time=3:
//   - time_left 3 -> 2 -> 1 -> 0, one step every 4 clks, with sec_tick pulses.
//   - level_ended: one pulse 2 clks after the last tick; digits 0/0; running=0 afterwards.
// - timer_time=120 -> time_left=99, tens=9, ones=9.
//   - After one tick: 98, then 9/8.
//   - At 90 -> 89, digits go 9/0 -> 8/9.
//   - low_time_warn rises when time_left=10.
// - timer_time=3, pause held 10 clks mid-run -> level_ended exactly 10 clks later than the unpaused run.
// - timer_time=9, all_collected at time_left=5, coincident with a tick:
//   - level_ended next clk; time_left stays 5; no second pulse later.
// - abort at time_left=2 -> running=0, no level_ended ever.
//   - A following start_level with timer_time=1 runs normally and ends with one pulse.
// - timer_time=0 -> level_ended 2 clks after start_level.
//   - start_level in the same cycle as expiry: reload wins, no pulse.

Source files
------------

// File: rtl/level_timer_pkg.sv
// Shared types and helpers for the per-level countdown timer.
package level_timer_pkg;

  localparam int unsigned TIME_W = 8;
  localparam int unsigned BCD_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

  // Decrement a two-digit BCD value by one; callers never pass 00.
  function automatic logic [2*BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] tens,
                                                 input logic [BCD_W-1:0] ones);
    logic [2*BCD_W-1:0] res;
    if (ones == '0) begin
      res = {tens - 1'b1, BCD_W'(9)};
    end else begin
      res = {tens, ones - 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/level_timer_if.sv
// Game controller <-> level timer signal bundle.
interface level_timer_if;
  import level_timer_pkg::*;

  // controller -> timer
  logic              start_level;
  logic [TIME_W-1:0] timer_time;
  logic              pause;
  logic              all_collected;
  logic              abort;

  // timer -> controller / HUD
  logic              level_ended;
  logic [TIME_W-1:0] time_left;
  logic [BCD_W-1:0]  time_tens;
  logic [BCD_W-1:0]  time_ones;
  logic              sec_tick;
  logic              running;
  logic              low_time_warn;

  modport master (
    output start_level, timer_time, pause, all_collected, abort,
    input  level_ended, time_left, time_tens, time_ones, sec_tick, running, low_time_warn
  );

  modport slave (
    input  start_level, timer_time, pause, all_collected, abort,
    output level_ended, time_left, time_tens, time_ones, sec_tick, running, low_time_warn
  );

endinterface

// File: rtl/level_timer_bin2bcd_99.sv
// Combinational binary (0..99) to two BCD digits; only used when loading a level time.
module bin2bcd_99
  import level_timer_pkg::*;
(
  input  logic [TIME_W-1:0] value,
  output logic [BCD_W-1:0]  tens,
  output logic [BCD_W-1:0]  ones
);

  // Divide by ten; input is already clamped to two digits by the caller.
  always_comb begin
    tens = BCD_W'(value / TIME_W'(10));
    ones = BCD_W'(value % TIME_W'(10));
  end

endmodule

// File: rtl/level_timer.sv
// Per-level countdown timer: loads a level time, counts down one step per game
// second, reports the end of the level and drives the HUD digits and warning.
module level_timer
  import level_timer_pkg::*;
#(
  parameter int unsigned       TICK_DIV = 31_500_000,
  parameter logic [TIME_W-1:0] MAX_TIME = 8'd99,
  parameter logic [TIME_W-1:0] LOW_TIME = 8'd10
) (
  input  logic           clk,
  input  logic           resetN,
  level_timer_if.slave   bus
);

  localparam int unsigned        PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  timer_state_t      state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TIME_W-1:0] tl_q, tl_d;
  logic [BCD_W-1:0]  tens_q, tens_d;
  logic [BCD_W-1:0]  ones_q, ones_d;
  logic              le_q, le_d;
  logic              tick_q, tick_d;
  logic              run_q, run_d;
  logic              warn_q, warn_d;
  logic              step;

  logic [TIME_W-1:0] load_val;
  logic [BCD_W-1:0]  load_tens;
  logic [BCD_W-1:0]  load_ones;

  assign load_val = (bus.timer_time > MAX_TIME) ? MAX_TIME : bus.timer_time;

  bin2bcd_99 u_load_bcd (
    .value (load_val),
    .tens  (load_tens),
    .ones  (load_ones)
  );

  // Next-state, countdown and registered-output values.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tl_d    = tl_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    le_d    = 1'b0;
    tick_d  = 1'b0;
    step    = 1'b0;

    if (bus.start_level) begin
      state_d = RUN;
      presc_d = '0;
      tl_d    = load_val;
      tens_d  = load_tens;
      ones_d  = load_ones;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.abort) begin
            state_d = IDLE;
          end else if (bus.all_collected) begin
            state_d = EXPIRED;
            le_d    = 1'b1;
          end else if (tl_q == '0) begin
            state_d = EXPIRED;
            le_d    = 1'b1;
          end else if (bus.pause) begin
            state_d = PAUSED;
          end else begin
            step = 1'b1;
          end
        end
        PAUSED: begin
          if (bus.abort) begin
            state_d = IDLE;
          end else if (bus.all_collected) begin
            state_d = EXPIRED;
            le_d    = 1'b1;
          end else if (!bus.pause) begin
            // Count on the resume cycle so a pause costs exactly its own length.
            state_d = RUN;
            step    = 1'b1;
          end
        end
        default: begin
          // IDLE and EXPIRED wait for start_level.
        end
      endcase
    end

    if (step) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (tl_q != '0) begin
          tl_d             = tl_q - 1'b1;
          {tens_d, ones_d} = bcd_dec(tens_q, ones_q);
          tick_d           = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    run_d  = (state_d == RUN) || (state_d == PAUSED);
    warn_d = run_d && (tl_d != '0) && (tl_d <= LOW_TIME);
  end

  // State, prescaler and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      presc_q <= '0;
      tl_q    <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      le_q    <= 1'b0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      warn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tl_q    <= tl_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      le_q    <= le_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
      warn_q  <= warn_d;
    end
  end

  assign bus.level_ended   = le_q;
  assign bus.time_left     = tl_q;
  assign bus.time_tens     = tens_q;
  assign bus.time_ones     = ones_q;
  assign bus.sec_tick      = tick_q;
  assign bus.running       = run_q;
  assign bus.low_time_warn = warn_q;

endmodule

// File: tb/tb_level_timer.sv
// Self-checking bench for level_timer with a fast game second (4 clocks).
module tb_level_timer;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  level_timer_if bus();

  level_timer #(
    .TICK_DIV (TD),
    .MAX_TIME (8'd99),
    .LOW_TIME (8'd10)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time left is the loaded value minus whole game seconds
  // of counted (unpaused) cycles since the load.
  int m_mode = 0;   // 0 idle, 1 active, 2 ended
  bit m_paused = 0;
  int m_load = 0;
  int m_cnt = 0;
  int m_tl = 0;
  bit m_le = 0;
  bit m_tick = 0;

  task automatic model_step();
    m_le   = 0;
    m_tick = 0;
    if (bus.start_level) begin
      m_load   = (int'(bus.timer_time) > 99) ? 99 : int'(bus.timer_time);
      m_cnt    = 0;
      m_paused = 0;
      m_mode   = 1;
      m_tl     = m_load;
    end else if (m_mode == 1) begin
      if (bus.abort) begin
        m_mode = 0;
      end else if (bus.all_collected) begin
        m_mode = 2;
        m_le   = 1;
      end else if (!m_paused && m_tl == 0) begin
        m_mode = 2;
        m_le   = 1;
      end else if (bus.pause) begin
        m_paused = 1;
      end else begin
        m_paused = 0;
        m_cnt++;
        if (m_cnt % TD == 0) m_tick = 1;
        m_tl = m_load - m_cnt / TD;
      end
    end
  endtask

  task automatic compare_model();
    int run;
    run = (m_mode == 1) ? 1 : 0;
    check("m_time_left", bus.time_left, m_tl);
    check("m_tens", bus.time_tens, m_tl / 10);
    check("m_ones", bus.time_ones, m_tl % 10);
    check("m_level_ended", bus.level_ended, m_le);
    check("m_sec_tick", bus.sec_tick, m_tick);
    check("m_running", bus.running, run);
    check("m_warn", bus.low_time_warn, (run == 1 && m_tl != 0 && m_tl <= 10) ? 1 : 0);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_in(input bit st, input int tt, input bit pa, input bit ac, input bit ab);
    bus.start_level   = st;
    bus.timer_time    = 8'(tt);
    bus.pause         = pa;
    bus.all_collected = ac;
    bus.abort         = ab;
  endtask

  typedef struct {
    bit st; int tt; bit pa; bit ac; bit ab;
    int tl; int le; int tick; int run; int warn;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(bit st, int tt, bit pa, bit ac, bit ab,
                              int tl, int le, int tick, int run, int warn);
    vec_t v;
    v.st = st; v.tt = tt; v.pa = pa; v.ac = ac; v.ab = ab;
    v.tl = tl; v.le = le; v.tick = tick; v.run = run; v.warn = warn;
    return v;
  endfunction

  // Start a level with timer_time=3 and report the cycle index of level_ended,
  // with pause held high on cycles pstart..pend.
  task automatic run3(input int pstart, input int pend, output int le_at);
    le_at = -1;
    set_in(1, 3, 0, 0, 0);
    cyc();
    for (int i = 1; i <= 40; i++) begin
      set_in(0, 0, (i >= pstart && i <= pend), 0, 0);
      cyc();
      if (bus.level_ended && le_at < 0) le_at = i;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int cnt;
    int pos;
    int a;
    int b;
    bit pa;

    tbl[0]  = mk(1, 3, 0, 0, 0, 3, 0, 0, 1, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 3, 0, 0, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 2, 0, 1, 1, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 2, 0, 0, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 2, 0, 0, 1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 2, 0, 0, 1, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset
    set_in(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_time_left", bus.time_left, 0);
    check("rst_level_ended", bus.level_ended, 0);
    check("rst_running", bus.running, 0);
    check("rst_sec_tick", bus.sec_tick, 0);
    check("rst_warn", bus.low_time_warn, 0);
    check("rst_digits", {bus.time_tens, bus.time_ones}, 0);
    resetN = 1'b1;

    // Table: plain 3-second level
    foreach (tbl[i]) begin
      set_in(tbl[i].st, tbl[i].tt, tbl[i].pa, tbl[i].ac, tbl[i].ab);
      cyc();
      check($sformatf("tbl%0d_time_left", i), bus.time_left, tbl[i].tl);
      check($sformatf("tbl%0d_level_ended", i), bus.level_ended, tbl[i].le);
      check($sformatf("tbl%0d_sec_tick", i), bus.sec_tick, tbl[i].tick);
      check($sformatf("tbl%0d_running", i), bus.running, tbl[i].run);
      check($sformatf("tbl%0d_warn", i), bus.low_time_warn, tbl[i].warn);
    end

    // Saturating load and BCD borrow
    set_in(1, 120, 0, 0, 0);
    cyc();
    check("sat_time_left", bus.time_left, 99);
    check("sat_tens", bus.time_tens, 9);
    check("sat_ones", bus.time_ones, 9);
    set_in(0, 0, 0, 0, 0);
    repeat (4) cyc();
    check("t98_time_left", bus.time_left, 98);
    check("t98_digits", {bus.time_tens, bus.time_ones}, 8'h98);
    guard = 0;
    while (bus.time_left != 90 && guard < 500) begin cyc(); guard++; end
    check("t90_digits", {bus.time_tens, bus.time_ones}, 8'h90);
    guard = 0;
    while (bus.time_left == 90 && guard < 10) begin cyc(); guard++; end
    check("t89_time_left", bus.time_left, 89);
    check("t89_digits", {bus.time_tens, bus.time_ones}, 8'h89);
    guard = 0;
    while (bus.time_left != 11 && guard < 500) begin cyc(); guard++; end
    check("t11_warn", bus.low_time_warn, 0);
    guard = 0;
    while (bus.time_left == 11 && guard < 10) begin cyc(); guard++; end
    check("t10_time_left", bus.time_left, 10);
    check("t10_warn", bus.low_time_warn, 1);
    set_in(0, 0, 0, 0, 1);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc();

    // Pause shifts expiry by the paused length
    run3(100, 0, a);
    check("nopause_end_cycle", a, 13);
    run3(6, 15, b);
    check("pause_end_cycle", b, 23);

    // all_collected coincident with a tick at time_left=5
    set_in(1, 9, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) cyc();
    set_in(0, 0, 0, 1, 0);
    cyc();
    check("ac_level_ended", bus.level_ended, 1);
    check("ac_time_left", bus.time_left, 5);
    check("ac_sec_tick", bus.sec_tick, 0);
    check("ac_running", bus.running, 0);
    set_in(0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin cyc(); if (bus.level_ended) cnt++; end
    check("ac_extra_pulses", cnt, 0);
    check("ac_time_hold", bus.time_left, 5);

    // Abort at time_left=2, then a normal 1-second level
    set_in(1, 3, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc();
    check("ab_pre_time_left", bus.time_left, 2);
    set_in(0, 0, 0, 0, 1);
    cyc();
    check("ab_running", bus.running, 0);
    check("ab_time_left", bus.time_left, 2);
    set_in(0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin cyc(); if (bus.level_ended) cnt++; end
    check("ab_no_pulse", cnt, 0);
    set_in(1, 1, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cnt = 0;
    pos = -1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      if (bus.level_ended) begin cnt++; pos = i; end
    end
    check("ab_next_pulses", cnt, 1);
    check("ab_next_pulse_cycle", pos, 5);

    // Zero-time level, and reload racing expiry
    set_in(1, 0, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc();
    check("zero_level_ended", bus.level_ended, 1);
    check("zero_running", bus.running, 0);
    cyc();
    set_in(1, 0, 0, 0, 0);
    cyc();
    cyc();
    check("race_level_ended", bus.level_ended, 0);
    check("race_running", bus.running, 1);
    set_in(0, 0, 0, 0, 0);
    cyc();
    check("race_later_pulse", bus.level_ended, 1);

    // Randomized traffic against the model
    pa = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) pa = ~pa;
      set_in($urandom_range(0, 59) == 0,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 130)) : int'($urandom_range(0, 6)),
             pa,
             $urandom_range(0, 99) == 0,
             $urandom_range(0, 149) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
